// File: rtl/instr_mem_ctrl_if.sv
// Fetch and program-load bundle for the instruction memory.
// master = fetch/boot side, slave = memory controller.
interface instr_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 7
);
    logic [31:0]           Address;
    logic                  Fetch_Req;
    logic                  Fetch_Ready;
    logic [DATA_WIDTH-1:0] Instruction;
    logic                  Instr_Valid;
    logic                  Addr_Fault;
    logic                  Load_Start;
    logic                  Load_En;
    logic [DATA_WIDTH-1:0] Load_Data;
    logic [ADDR_BITS:0]    Load_Count;
    logic                  Load_Full;
    logic                  Busy;

    modport master (
        output Address, Fetch_Req,
        output Load_Start, Load_En, Load_Data,
        input  Fetch_Ready, Instruction,
        input  Instr_Valid, Addr_Fault,
        input  Load_Count, Load_Full, Busy
    );

    modport slave (
        input  Address, Fetch_Req,
        input  Load_Start, Load_En, Load_Data,
        output Fetch_Ready, Instruction,
        output Instr_Valid, Addr_Fault,
        output Load_Count, Load_Full, Busy
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with streaming load port, clear sweep
// after reset and registered fetch with fault reporting.
module instr_mem_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_BITS      = 7,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD      = '0
) (
    input logic             Clk,
    input logic             Reset_n,
    instr_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {CLEAR, READY} state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_BITS-1:0]  sweep_cnt;
    logic [ADDR_BITS:0]    load_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_clear;
    logic                  in_ready;
    logic                  fetch_rdy;
    logic                  fetch_go;
    logic                  load_full;
    logic                  ld_first;
    logic                  ld_next;
    logic                  fault;
    logic [ADDR_BITS-1:0]  raddr;
    logic                  we;
    logic [ADDR_BITS-1:0]  waddr;
    logic [DATA_WIDTH-1:0] wdata;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: begin
                if (sweep_cnt == ADDR_BITS'(DEPTH - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: state_nxt = READY;
            default: state_nxt = RST_STATE;
        endcase
    end

    always_comb begin
        in_clear  = (state == CLEAR);
        in_ready  = (state == READY);
        fetch_rdy = in_ready & ~bus.Load_En & ~bus.Load_Start;
        fetch_go  = fetch_rdy & bus.Fetch_Req;
    end

    assign bus.Busy        = in_clear;
    assign bus.Fetch_Ready = fetch_rdy;

    assign load_full      = (load_ptr == (ADDR_BITS+1)'(DEPTH));
    assign bus.Load_Full  = load_full;
    assign bus.Load_Count = load_ptr;

    // Load_Start with Load_En restarts the program at word 0.
    assign ld_first = in_ready & bus.Load_Start & bus.Load_En;
    assign ld_next  = in_ready & ~bus.Load_Start & bus.Load_En
                    & ~load_full;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = bus.Load_Data;
        unique case (1'b1)
            in_clear: begin
                we    = 1'b1;
                waddr = sweep_cnt;
                wdata = FILL_WORD;
            end
            ld_first: begin
                we    = 1'b1;
                waddr = '0;
            end
            ld_next: begin
                we    = 1'b1;
                waddr = load_ptr[ADDR_BITS-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sweep_cnt <= '0;
        end else if (in_clear) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            load_ptr <= '0;
        end else if (in_ready) begin
            if (bus.Load_Start) begin
                load_ptr <= bus.Load_En ? (ADDR_BITS+1)'(1) : '0;
            end else if (ld_next) begin
                load_ptr <= load_ptr + 1'b1;
            end
        end
    end

    assign raddr = bus.Address[ADDR_BITS+1:2];
    assign fault = (|bus.Address[1:0])
                 | (|bus.Address[31:ADDR_BITS+2]);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Instruction <= FILL_WORD;
            bus.Instr_Valid <= 1'b0;
            bus.Addr_Fault  <= 1'b0;
        end else begin
            bus.Instr_Valid <= fetch_go;
            if (fetch_go) begin
                bus.Addr_Fault  <= fault;
                bus.Instruction <= fault ? FILL_WORD : mem[raddr];
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed plus randomized bench for instr_mem_ctrl against
// a word-array reference model of the memory and load pointer.
module tb_instr_mem_ctrl;
    localparam int          DW    = 32;
    localparam int          AB    = 7;
    localparam int          DEPTH = 1 << AB;
    localparam logic [31:0] FILL  = 32'h0000_0000;

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    instr_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

    instr_mem_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_BITS     (AB),
        .CLEAR_ON_RESET(1'b1),
        .FILL_WORD     (FILL)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    int          rptr;
    bit          mdl_ready;
    logic [31:0] exp_instr;
    logic        exp_fault;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_ready = 1'b0;
        rptr      = 0;
        exp_instr = FILL;
        exp_fault = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_instr", bus.Instruction, FILL);
        chk("rst_valid", bus.Instr_Valid, 0);
        chk("rst_fault", bus.Addr_Fault, 0);
        chk("rst_count", bus.Load_Count, 0);
        chk("rst_full", bus.Load_Full, 0);
        chk("rst_busy", bus.Busy, 1);
        chk("rst_ready", bus.Fetch_Ready, 0);
    endtask

    task automatic idle();
        bus.Fetch_Req  = 1'b0;
        bus.Address    = '0;
        bus.Load_Start = 1'b0;
        bus.Load_En    = 1'b0;
        bus.Load_Data  = '0;
    endtask

    // Called at a falling edge; releases reset and counts busy cycles.
    task automatic run_sweep(input int abort_at);
        int n;
        n = 0;
        Reset_n = 1'b1;
        while (bus.Busy === 1'b1 && n < 300) begin
            bus.Fetch_Req  = 1'b1;
            bus.Address    = $urandom & 32'h0000_01FC;
            bus.Load_Start = 1'($urandom_range(0, 1));
            bus.Load_En    = 1'($urandom_range(0, 1));
            bus.Load_Data  = $urandom;
            #1;
            chk("clr_ready", bus.Fetch_Ready, 0);
            chk("clr_valid", bus.Instr_Valid, 0);
            chk("clr_count", bus.Load_Count, 0);
            n++;
            if (n == abort_at) return;
            @(negedge Clk);
        end
        chk("sweep_len", n, DEPTH);
        idle();
        mdl_ready = 1'b1;
        rptr      = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
    endtask

    // One cycle: drive at the falling edge, check after the next one.
    task automatic step(input logic req, input logic [31:0] addr,
                        input logic ls, input logic le,
                        input logic [31:0] ld);
        logic exp_rdy;
        logic acc;
        bus.Fetch_Req  = req;
        bus.Address    = addr;
        bus.Load_Start = ls;
        bus.Load_En    = le;
        bus.Load_Data  = ld;
        #1;
        exp_rdy = mdl_ready && !ls && !le;
        chk("fetch_ready", bus.Fetch_Ready, exp_rdy);
        acc = req && exp_rdy;
        if (acc) begin
            if (addr % 4 != 0 || addr >= 32'(DEPTH * 4)) begin
                exp_fault = 1'b1;
                exp_instr = FILL;
            end else begin
                exp_fault = 1'b0;
                exp_instr = ref_mem[int'(addr / 4)];
            end
        end
        if (mdl_ready) begin
            if (ls) rptr = 0;
            if (le && rptr < DEPTH) begin
                ref_mem[rptr] = ld;
                rptr++;
            end
        end
        @(negedge Clk);
        chk("instr_valid", bus.Instr_Valid, acc);
        chk("instruction", bus.Instruction, exp_instr);
        chk("addr_fault", bus.Addr_Fault, exp_fault);
        chk("load_count", bus.Load_Count, rptr);
        chk("load_full", bus.Load_Full, rptr == DEPTH);
    endtask

    function automatic logic [31:0] rand_addr();
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 0)
            return ($urandom_range(0, DEPTH - 1) << 2)
                 | $urandom_range(1, 3);
        if (kind == 1)
            return ($urandom & 32'hFFFF_FFFC)
                 | (32'h1 << $urandom_range(AB + 2, 31));
        return $urandom_range(0, DEPTH - 1) << 2;
    endfunction

    logic [31:0] first_word;
    logic [31:0] d;

    initial begin
        Reset_n = 1'b0;
        idle();
        mdl_reset();
        repeat (3) @(negedge Clk);
        chk_reset();

        run_sweep(0);
        step(1'b1, 32'h1FC, 1'b0, 1'b0, '0);

        step(1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h3404_0000);
        step(1'b0, '0, 1'b0, 1'b1, 32'h3405_0100);
        step(1'b0, '0, 1'b0, 1'b1, 32'h2011_0000);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0);
        chk("dir_ld3", bus.Instruction, 32'h3405_0100);

        step(1'b0, '0, 1'b1, 1'b0, '0);
        first_word = $urandom;
        step(1'b0, '0, 1'b0, 1'b1, first_word);
        for (int i = 1; i < DEPTH; i++)
            step(1'b0, '0, 1'b0, 1'b1, $urandom);
        step(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("dir_full", bus.Load_Full, 1);
        chk("dir_cnt128", bus.Load_Count, 128);
        step(1'b1, 32'h0, 1'b0, 1'b0, '0);
        chk("dir_first", bus.Instruction, first_word);

        step(1'b1, 32'h6, 1'b0, 1'b0, '0);
        step(1'b1, 32'h200, 1'b0, 1'b0, '0);
        chk("dir_oor", bus.Addr_Fault, 1);

        d = $urandom;
        step(1'b1, 32'h0, 1'b1, 1'b1, d);
        step(1'b1, 32'h0, 1'b0, 1'b0, '0);
        chk("dir_raw0", bus.Instruction, d);
        d = $urandom;
        step(1'b1, 32'h4, 1'b0, 1'b1, d);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0);
        chk("dir_raw1", bus.Instruction, d);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), rand_addr(),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0), $urandom);

        step(1'b0, '0, 1'b1, 1'b1, 32'h1234_5678);
        step(1'b1, 32'h0, 1'b0, 1'b0, '0);
        bus.Fetch_Req = 1'b1;
        bus.Address   = 32'h0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk_reset();
        mdl_reset();
        @(posedge Clk);
        #1;
        chk("rst_drop", bus.Instr_Valid, 0);
        @(negedge Clk);

        run_sweep(60);
        #1;
        Reset_n = 1'b0;
        #1;
        chk_reset();
        mdl_reset();
        @(negedge Clk);
        run_sweep(0);

        step(1'b1, 32'h0, 1'b0, 1'b0, '0);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0);
        step(1'b1, 32'h1FC, 1'b0, 1'b0, '0);
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), rand_addr(),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0), $urandom);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d checks",
                 checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised, clocked instruction memory for the processor fetch stage.
- Replaces hard-coded ROM contents with:
  - a streaming program-load port,
  - optional clear-on-reset sweep,
  - registered read with valid/fault signalling.
- Sits between the PC/fetch logic and the instruction register.
- Programs are loaded by the testbench or boot logic before the core is released.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_BITS, 7, word-index bits; depth = 2**ADDR_BITS (default 128 words)
CLEAR_ON_RESET, 1, 1 = sweep every word to FILL_WORD after reset; 0 = skip sweep, contents retained
FILL_WORD, 32'h00000000, value written by the sweep and returned on faulted fetches (NOP)

Ports:
Clk  input  1  single clock; all state changes on rising edge
Reset_n  input  1  asynchronous, active-low reset
Address  input  32  byte address of requested instruction
Fetch_Req  input  1  fetch request, sampled when Fetch_Ready=1
Fetch_Ready  output  1  fetch can be accepted this cycle
Instruction  output  DATA_WIDTH  registered instruction word
Instr_Valid  output  1  one-cycle pulse: Instruction/Addr_Fault valid for accepted fetch
Addr_Fault  output  1  accepted fetch was misaligned or out of range
Load_Start  input  1  pulse: reset load pointer to word 0
Load_En  input  1  write Load_Data at load pointer, then increment
Load_Data  input  DATA_WIDTH  program word to store
Load_Count  output  ADDR_BITS+1  number of words loaded since last Load_Start
Load_Full  output  1  load pointer reached depth
Busy  output  1  clear sweep in progress

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - Instruction=FILL_WORD; Instr_Valid=0; Addr_Fault=0.
  - Load_Count=0; Load_Full=0; sweep counter=0.
  - State = CLEAR if CLEAR_ON_RESET=1, else READY; Busy=CLEAR_ON_RESET.
  - Memory array itself is not reset.
- CLEAR state:
  - Each cycle writes FILL_WORD to word[sweep counter], then increments the counter.
  - After word DEPTH-1 is written (DEPTH cycles after reset release), moves to READY; Busy falls in the same edge.
  - Load_Start, Load_En and Fetch_Req are ignored; Fetch_Ready=0.
- Fetch_Ready = (state==READY) & ~Load_En & ~Load_Start. A load in the same cycle has priority; the fetch is not accepted and must be held.
- Fetch: accepted when Fetch_Req & Fetch_Ready. On the next rising edge (latency 1):
  - Instr_Valid=1 for exactly one cycle.
  - Index = Address[ADDR_BITS+1:2].
  - Fault if Address[1:0]!=0 or Address[31:ADDR_BITS+2]!=0. On fault: Addr_Fault=1, Instruction=FILL_WORD.
  - Otherwise: Addr_Fault=0, Instruction=word[Index].
- Back-to-back fetches every cycle give full throughput.
- With no accepted fetch, Instruction and Addr_Fault hold their last values and Instr_Valid=0.
- Load, in READY state only:
  - Load_Start zeroes the pointer and clears Load_Full.
  - Load_En alone writes word[pointer] and increments the pointer.
  - Load_Start & Load_En together: writes word 0, pointer becomes 1.
  - Load_Count mirrors the pointer.
  - When pointer == DEPTH: Load_Full=1 and further Load_En is ignored. No wrap; pointer saturates.
- Read-after-write: a fetch accepted in the cycle after a word was loaded returns the new data.
- Reset mid-operation:
  - In-flight fetch is dropped; no Instr_Valid is produced.
  - A partial sweep restarts from word 0.
  - A partial load is abandoned; loaded words remain unless the sweep overwrites them.

Test Plan:
- Reset with CLEAR_ON_RESET=1, depth 128 -> Busy=1 for exactly 128 cycles and Fetch_Ready=0 throughout; then fetch 0x1FC -> Instr_Valid pulse, Instruction=0x00000000, Addr_Fault=0.
- Load_Start, then Load_En x3 with 0x34040000, 0x34050100, 0x20110000 -> Load_Count=3; fetch 0x4 -> next cycle Instruction=0x34050100.
- Load 128 words, then one extra Load_En with 0xDEADBEEF -> Load_Full=1, Load_Count=128; fetch 0x0 returns the first loaded word, unchanged.
- Fetch 0x6 (misaligned) and 0x200 (out of range for ADDR_BITS=7) -> Instr_Valid=1, Addr_Fault=1, Instruction=FILL_WORD each.
- Fetch_Req held high while Load_En=1 -> Fetch_Ready=0 and no Instr_Valid; fetch accepted the cycle after Load_En drops, returning the newly written word.
- Assert Reset_n=0 mid-sweep (cycle 60) and with a fetch outstanding -> outputs at reset values immediately, no Instr_Valid, sweep restarts and lasts a full 128 cycles.
